// File: rtl/bch_frame_scheduler.sv
// Purpose: frames a serial bit stream into N-bit codewords (ping-pong banks), feeds the BCH decoder,
//          collects error-location strobes and unloads each codeword with located bits flipped.
// Latency: first out_valid one cycle after dec_done (or after the ST_WAIT timeout expires).
// Backpressure: in_ready low while the write bank is full; dec_ready and out_ready stall feed/unload.
// Optional build macro BCH_SCHED_STATS_EN adds the stat_frames/stat_corrected/stat_failed counters.
module bch_frame_scheduler #(
  parameter int N       = 63,
  parameter int T       = 2,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_data,
  output logic       in_ready,
  output logic       dec_start,
  output logic       dec_valid,
  output logic       dec_data,
  input  logic       dec_ready,
  input  logic       dec_loc_valid,
  input  logic [5:0] dec_loc,
  input  logic       dec_done,
  input  logic       dec_fail,
  output logic       out_valid,
  output logic       out_data,
  input  logic       out_ready,
  output logic       out_last,
  output logic       out_fail
`ifdef BCH_SCHED_STATS_EN
  ,
  output logic [15:0] stat_frames,
  output logic [15:0] stat_corrected,
  output logic [15:0] stat_failed
`endif
);

  // loc_cnt must hold 0..T+1 (saturation value marks "too many strobes")
  localparam int LCW = $clog2(T + 2);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FEED   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_UNLOAD = 2'd3
  } state_t;

  logic [N-1:0]   bank_q [2];
  logic [N-1:0]   bank_d [2];
  logic [1:0]     full_q, full_d, full_set, full_clr;
  logic [5:0]     wr_cnt_q, wr_cnt_d;
  logic           wr_sel_q, wr_sel_d;
  logic           rd_sel_q, rd_sel_d;
  state_t         state_q, state_d;
  logic [5:0]     fd_cnt_q, fd_cnt_d;
  logic [5:0]     ul_cnt_q, ul_cnt_d;
  logic [N-1:0]   err_mask_q, err_mask_d;
  logic [LCW-1:0] loc_cnt_q, loc_cnt_d;
  logic [7:0]     timer_q, timer_d;
  logic           fail_q, fail_d;
  logic           frame_end;

  assign in_ready = ~full_q[wr_sel_q];

  // Write side: store accepted bit, close the bank after bit N-1 and move to the other bank
  always_comb begin
    bank_d   = bank_q;
    wr_cnt_d = wr_cnt_q;
    wr_sel_d = wr_sel_q;
    full_set = 2'b00;
    if (in_valid && in_ready) begin
      bank_d[wr_sel_q][wr_cnt_q] = in_data;
      if (wr_cnt_q == 6'(N - 1)) begin
        wr_cnt_d           = 6'd0;
        full_set[wr_sel_q] = 1'b1;
        wr_sel_d           = ~wr_sel_q;
      end else begin
        wr_cnt_d = wr_cnt_q + 6'd1;
      end
    end
  end

  // Freeing and filling always hit different banks, so set and clear never overlap
  assign full_d = (full_q | full_set) & ~full_clr;

  // Read FSM: feed decoder, gather error locations, unload corrected codeword
  always_comb begin
    state_d    = state_q;
    rd_sel_d   = rd_sel_q;
    fd_cnt_d   = fd_cnt_q;
    ul_cnt_d   = ul_cnt_q;
    err_mask_d = err_mask_q;
    loc_cnt_d  = loc_cnt_q;
    timer_d    = timer_q;
    fail_d     = fail_q;
    full_clr   = 2'b00;
    frame_end  = 1'b0;
    dec_start  = 1'b0;
    dec_valid  = 1'b0;
    dec_data   = 1'b0;
    out_valid  = 1'b0;
    out_data   = 1'b0;
    out_last   = 1'b0;
    out_fail   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (full_q[rd_sel_q]) begin
          state_d  = ST_FEED;
          fd_cnt_d = 6'd0;
        end
      end
      ST_FEED: begin
        dec_valid = 1'b1;
        dec_data  = bank_q[rd_sel_q][fd_cnt_q];
        dec_start = (fd_cnt_q == 6'd0);
        if (dec_ready) begin
          if (fd_cnt_q == 6'(N - 1)) begin
            fd_cnt_d   = 6'd0;
            state_d    = ST_WAIT;
            err_mask_d = '0;
            loc_cnt_d  = '0;
            timer_d    = 8'd0;
            fail_d     = 1'b0;
          end else begin
            fd_cnt_d = fd_cnt_q + 6'd1;
          end
        end
      end
      ST_WAIT: begin
        timer_d = timer_q + 8'd1;
        if (dec_loc_valid) begin
          if ((loc_cnt_q < LCW'(T)) && (dec_loc < 6'(N))) begin
            err_mask_d[dec_loc] = 1'b1;
          end else begin
            fail_d = 1'b1;
          end
          if (loc_cnt_q != LCW'(T + 1)) begin
            loc_cnt_d = loc_cnt_q + LCW'(1);
          end
        end
        // A strobe in the dec_done cycle is already folded into fail_d/err_mask_d above
        if (dec_done) begin
          state_d  = ST_UNLOAD;
          ul_cnt_d = 6'd0;
          fail_d   = fail_d | dec_fail;
        end else if (timer_q == 8'(TIMEOUT)) begin
          state_d  = ST_UNLOAD;
          ul_cnt_d = 6'd0;
          fail_d   = 1'b1;
        end
      end
      ST_UNLOAD: begin
        out_valid = 1'b1;
        out_data  = bank_q[rd_sel_q][ul_cnt_q] ^ (~fail_q & err_mask_q[ul_cnt_q]);
        out_fail  = fail_q;
        out_last  = (ul_cnt_q == 6'(N - 1));
        if (out_ready) begin
          if (ul_cnt_q == 6'(N - 1)) begin
            ul_cnt_d           = 6'd0;
            full_clr[rd_sel_q] = 1'b1;
            rd_sel_d           = ~rd_sel_q;
            state_d            = ST_IDLE;
            frame_end          = 1'b1;
          end else begin
            ul_cnt_d = ul_cnt_q + 6'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset drops every buffered and in-flight frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_q[0]  <= '0;
      bank_q[1]  <= '0;
      full_q     <= 2'b00;
      wr_cnt_q   <= 6'd0;
      wr_sel_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
      state_q    <= ST_IDLE;
      fd_cnt_q   <= 6'd0;
      ul_cnt_q   <= 6'd0;
      err_mask_q <= '0;
      loc_cnt_q  <= '0;
      timer_q    <= 8'd0;
      fail_q     <= 1'b0;
    end else begin
      bank_q[0]  <= bank_d[0];
      bank_q[1]  <= bank_d[1];
      full_q     <= full_d;
      wr_cnt_q   <= wr_cnt_d;
      wr_sel_q   <= wr_sel_d;
      rd_sel_q   <= rd_sel_d;
      state_q    <= state_d;
      fd_cnt_q   <= fd_cnt_d;
      ul_cnt_q   <= ul_cnt_d;
      err_mask_q <= err_mask_d;
      loc_cnt_q  <= loc_cnt_d;
      timer_q    <= timer_d;
      fail_q     <= fail_d;
    end
  end

`ifdef BCH_SCHED_STATS_EN
  logic [15:0] stat_frames_q, stat_frames_d;
  logic [15:0] stat_corrected_q, stat_corrected_d;
  logic [15:0] stat_failed_q, stat_failed_d;

  assign stat_frames    = stat_frames_q;
  assign stat_corrected = stat_corrected_q;
  assign stat_failed    = stat_failed_q;

  // Saturating frame statistics, bumped when the last bit of a frame leaves
  always_comb begin
    stat_frames_d    = stat_frames_q;
    stat_corrected_d = stat_corrected_q;
    stat_failed_d    = stat_failed_q;
    if (frame_end) begin
      if (stat_frames_q != 16'hFFFF) stat_frames_d = stat_frames_q + 16'd1;
      if (fail_q) begin
        if (stat_failed_q != 16'hFFFF) stat_failed_d = stat_failed_q + 16'd1;
      end else if (loc_cnt_q != '0) begin
        if (stat_corrected_q != 16'hFFFF) stat_corrected_d = stat_corrected_q + 16'd1;
      end
    end
  end

  // Statistics registers, cleared only by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_frames_q    <= 16'd0;
      stat_corrected_q <= 16'd0;
      stat_failed_q    <= 16'd0;
    end else begin
      stat_frames_q    <= stat_frames_d;
      stat_corrected_q <= stat_corrected_d;
      stat_failed_q    <= stat_failed_d;
    end
  end
`endif

endmodule

// File: tb/tb_bch_frame_scheduler.sv
// Bench for bch_frame_scheduler: drives frames, models the decoder side, and scoreboards the
// corrected output stream against expectations computed from each frame's strobe plan.
module tb_bch_frame_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_data = 1'b0;
  logic       in_ready;
  logic       dec_start, dec_valid, dec_data;
  logic       dec_ready = 1'b0;
  logic       dec_loc_valid = 1'b0;
  logic [5:0] dec_loc = 6'd0;
  logic       dec_done = 1'b0;
  logic       dec_fail = 1'b0;
  logic       out_valid, out_data, out_last, out_fail;
  logic       out_ready = 1'b0;
`ifdef BCH_SCHED_STATS_EN
  logic [15:0] stat_frames, stat_corrected, stat_failed;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  typedef struct {
    logic [62:0] bits;
    logic        fail;
  } exp_t;

  exp_t        exp_q[$];
  logic [62:0] feed_q[$];

  bch_frame_scheduler dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .dec_start(dec_start), .dec_valid(dec_valid), .dec_data(dec_data), .dec_ready(dec_ready),
    .dec_loc_valid(dec_loc_valid), .dec_loc(dec_loc), .dec_done(dec_done), .dec_fail(dec_fail),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .out_last(out_last), .out_fail(out_fail)
`ifdef BCH_SCHED_STATS_EN
    , .stat_frames(stat_frames), .stat_corrected(stat_corrected), .stat_failed(stat_failed)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int pick(input int k, input int l0, input int l1, input int l2);
    if (k == 0) return l0;
    if (k == 1) return l1;
    return l2;
  endfunction

  // Scoreboard push: what the decoder should see and what the output should carry
  task automatic expect_frame(input logic [62:0] b, input int nloc, input int l0, input int l1,
                              input int l2, input bit done, input bit dfail);
    logic [62:0] mask;
    logic        f;
    exp_t        e;
    int          loc;
    mask = '0;
    f = !done || dfail || (nloc > 2);
    for (int k = 0; k < nloc; k++) begin
      loc = pick(k, l0, l1, l2);
      if (loc >= 63) f = 1'b1;
      else if (k < 2) mask[loc] = 1'b1;
    end
    e.bits = f ? b : (b ^ mask);
    e.fail = f;
    feed_q.push_back(b);
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input logic [62:0] b);
    logic hs;
    int   guard;
    for (int i = 0; i < 63; i++) begin
      in_valid = 1'b1;
      in_data  = b[i];
      guard    = 0;
      hs       = 1'b0;
      while (!hs && guard < 5000) begin
        hs = in_ready;
        @(posedge clk); #1;
        guard++;
      end
      if (!hs) chk("in_timeout", 1, 0);
    end
    in_valid = 1'b0;
  endtask

  task automatic dec_frame(input int nloc, input int l0, input int l1, input int l2,
                           input bit done, input bit dfail, input bit rnd);
    logic [62:0] got, expb;
    logic        dr;
    int          cnt, guard;
    expb  = feed_q.pop_front();
    got   = '0;
    cnt   = 0;
    guard = 0;
    while (cnt < 63 && guard < 20000) begin
      dr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      dec_ready = dr;
      if (dec_valid && dr) begin
        chk("dec_start", dec_start, cnt == 0);
        got[cnt] = dec_data;
        cnt++;
      end
      @(posedge clk); #1;
      guard++;
    end
    dec_ready = 1'b0;
    if (cnt < 63) chk("dec_timeout", 1, 0);
    chk("dec_bits", got, expb);
    for (int k = 0; k < nloc; k++) begin
      dec_loc_valid = 1'b1;
      dec_loc = 6'(pick(k, l0, l1, l2));
      @(posedge clk); #1;
    end
    dec_loc_valid = 1'b0;
    if (done) begin
      dec_done = 1'b1;
      dec_fail = dfail;
      @(posedge clk); #1;
      dec_done = 1'b0;
      dec_fail = 1'b0;
      chk("done_latency", out_valid, 1);
    end
  endtask

  task automatic collect_frame(input bit rnd);
    exp_t e;
    logic r;
    int   i, guard;
    e = exp_q.pop_front();
    i = 0;
    guard = 0;
    while (i < 63 && guard < 30000) begin
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = r;
      if (out_valid && r) begin
        chk("out_data", out_data, e.bits[i]);
        chk("out_last", out_last, i == 62);
        chk("out_fail", out_fail, e.fail);
        i++;
      end
      @(posedge clk); #1;
      guard++;
    end
    out_ready = 1'b0;
    if (i < 63) chk("out_timeout", 1, 0);
  endtask

  initial begin
    logic [62:0] b0, b1, b2;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_dec_valid", dec_valid, 0);
    chk("rst_dec_start", dec_start, 0);
    chk("rst_out_fail", out_fail, 0);
    chk("rst_out_last", out_last, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", in_ready, 1);

    // Clean all-zero codeword
    b0 = '0;
    expect_frame(b0, 0, 0, 0, 0, 1, 0);
    fork
      send_frame(b0);
      dec_frame(0, 0, 0, 0, 1, 0, 0);
      collect_frame(0);
    join

    // Two correctable strobes
    b0 = 63'({$urandom(), $urandom()});
    expect_frame(b0, 2, 5, 40, 0, 1, 0);
    fork
      send_frame(b0);
      dec_frame(2, 5, 40, 0, 1, 0, 0);
      collect_frame(0);
    join

    // Three strobes: too many, frame passes unmodified with fail
    b0 = 63'({$urandom(), $urandom()});
    expect_frame(b0, 3, 3, 7, 9, 1, 0);
    fork
      send_frame(b0);
      dec_frame(3, 3, 7, 9, 1, 0, 0);
      collect_frame(0);
    join

    // No dec_done: timeout forces a failed unload
    b0 = 63'({$urandom(), $urandom()});
    expect_frame(b0, 1, 11, 0, 0, 0, 0);
    fork
      send_frame(b0);
      dec_frame(1, 11, 0, 0, 0, 0, 0);
      collect_frame(0);
    join

    // Out-of-range location
    b0 = 63'({$urandom(), $urandom()});
    expect_frame(b0, 1, 63, 0, 0, 1, 0);
    fork
      send_frame(b0);
      dec_frame(1, 63, 0, 0, 1, 0, 0);
      collect_frame(0);
    join

    // Decoder reports uncorrectable
    b0 = 63'({$urandom(), $urandom()});
    expect_frame(b0, 1, 20, 0, 0, 1, 1);
    fork
      send_frame(b0);
      dec_frame(1, 20, 0, 0, 1, 1, 0);
      collect_frame(0);
    join

    // Three frames back to back with random decoder and output stalls
    b0 = 63'({$urandom(), $urandom()});
    b1 = 63'({$urandom(), $urandom()});
    b2 = 63'({$urandom(), $urandom()});
    expect_frame(b0, 1, 0, 0, 0, 1, 0);
    expect_frame(b1, 2, 62, 31, 0, 1, 0);
    expect_frame(b2, 0, 0, 0, 0, 1, 0);
    fork
      begin
        send_frame(b0);
        send_frame(b1);
        send_frame(b2);
      end
      begin
        dec_frame(1, 0, 0, 0, 1, 0, 1);
        dec_frame(2, 62, 31, 0, 1, 0, 1);
        dec_frame(0, 0, 0, 0, 1, 0, 1);
      end
      begin
        collect_frame(1);
        collect_frame(1);
        collect_frame(1);
      end
    join

    // Reset in the middle of an unload
    b0 = 63'({$urandom(), $urandom()});
    expect_frame(b0, 1, 2, 0, 0, 1, 0);
    fork
      send_frame(b0);
      dec_frame(1, 2, 0, 0, 1, 0, 0);
    join
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_unload_valid", out_valid, 1);
    rst = 1'b0;
    #1;
    chk("rst_mid_unload", out_valid, 0);
    out_ready = 1'b0;
    exp_q.delete();
    feed_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready2", in_ready, 1);

    // Frame after reset decodes correctly
    b0 = 63'({$urandom(), $urandom()});
    expect_frame(b0, 2, 12, 50, 0, 1, 0);
    fork
      send_frame(b0);
      dec_frame(2, 12, 50, 0, 1, 0, 0);
      collect_frame(0);
    join

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
